lsu_subword_ctrl: RTL and testbench

//  Load/store controller between the datapath and the data-cache port (dmemREN/dmemWEN/dmemaddr/dmemstore/dmemload/dhit).

---
 rtl/lsu_subword_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_subword_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword_ctrl.sv
// ============================================================================
// Module      : lsu_subword_ctrl
// Description : Load/store controller between the datapath and a data-cache
//               port without byte enables. Handles byte/half/word/dword
//               accesses with sign/zero extension, read-modify-write for
//               sub-word stores, and misaligned/illegal-size/timeout faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_subword_ctrl #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic [1:0]        resp_fault,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              dhit
);

  localparam int BYTES = WORD_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(WORD_W);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

  localparam logic [1:0] c_FLT_OK    = 2'b00;
  localparam logic [1:0] c_FLT_ALIGN = 2'b01;
  localparam logic [1:0] c_FLT_TMO   = 2'b10;
  localparam logic [1:0] c_FLT_SIZE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFF_W-1:0]  r_off;
  logic [WORD_W-1:0] r_wdata;
  logic              r_ready;
  logic              r_ren;
  logic              r_wen;
  logic              r_resp_valid;
  logic [WORD_W-1:0] r_rdata;
  logic [1:0]        r_fault;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;

  logic [3:0]        w_req_bytes;
  logic              w_illegal;
  logic              w_misal;
  logic              w_full;
  logic [IDX_W-1:0]  w_msb;
  logic [OFF_W+2:0]  w_shamt;
  logic [WORD_W-1:0] w_shifted;
  logic [WORD_W-1:0] w_lmask;
  logic [WORD_W-1:0] w_mask;
  logic [WORD_W-1:0] w_ext;
  logic [WORD_W-1:0] w_merged;
  logic              w_sign;
  logic              w_tmo;

  // Request classification: illegal size beats misalignment; full-word stores skip the read.
  always_comb begin
    w_req_bytes = 4'd1 << req_size;
    w_illegal   = int'(w_req_bytes) > BYTES;
    w_misal     = |(req_addr[2:0] & 3'(w_req_bytes - 4'd1));
    w_full      = int'(w_req_bytes) == BYTES;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    case (r_size)
      2'd0:    w_msb = IDX_W'(7);
      2'd1:    w_msb = IDX_W'(15);
      2'd2:    w_msb = IDX_W'(31);
      default: w_msb = IDX_W'(WORD_W - 1);
    endcase
    w_shamt   = {r_off, 3'b000};
    w_shifted = dmemload >> w_shamt;
    w_sign    = ~r_unsigned & w_shifted[w_msb];
    for (int i = 0; i < WORD_W; i++) begin
      w_lmask[i] = (i <= int'(w_msb));
      w_ext[i]   = (i <= int'(w_msb)) ? w_shifted[i] : w_sign;
    end
    w_mask   = w_lmask << w_shamt;
    w_merged = (dmemload & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
    w_tmo    = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Main controller FSM with registered Moore outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_ready      <= 1'b0;
      r_ren        <= 1'b0;
      r_wen        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_fault      <= c_FLT_OK;
      r_addr       <= '0;
      r_store      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_ready) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_off      <= req_addr[OFF_W-1:0];
            r_wdata    <= req_wdata;
            r_addr     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_ready    <= 1'b0;
            r_cnt      <= '0;
            if (w_illegal || w_misal) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_rdata      <= '0;
              r_fault      <= w_illegal ? c_FLT_SIZE : c_FLT_ALIGN;
            end else if (!req_we) begin
              r_state <= S_RD;
              r_ren   <= 1'b1;
            end else if (w_full) begin
              r_state <= S_WR;
              r_wen   <= 1'b1;
              r_store <= req_wdata;
            end else begin
              r_state <= S_RMW_RD;
              r_ren   <= 1'b1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_RD: begin
          if (dhit) begin
            r_state      <= S_RESP;
            r_ren        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_ext;
            r_fault      <= c_FLT_OK;
          end else if (w_tmo) begin
            r_state      <= S_RESP;
            r_ren        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_rdata      <= '0;
            r_fault      <= c_FLT_TMO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RMW_RD: begin
          if (dhit) begin
            r_state <= S_WR;
            r_ren   <= 1'b0;
            r_wen   <= 1'b1;
            r_store <= w_merged;
            r_cnt   <= '0;
          end else if (w_tmo) begin
            r_state      <= S_RESP;
            r_ren        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_rdata      <= '0;
            r_fault      <= c_FLT_TMO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WR: begin
          if (dhit || w_tmo) begin
            r_state      <= S_RESP;
            r_wen        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_rdata      <= '0;
            r_fault      <= dhit ? c_FLT_OK : c_FLT_TMO;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_ready      <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_fault = r_fault;
  assign dmemREN    = r_ren;
  assign dmemWEN    = r_wen;
  assign dmemaddr   = r_addr;
  assign dmemstore  = r_store;

endmodule

`default_nettype wire

// File: tb/tb_lsu_subword_ctrl.sv
// ============================================================================
// Module      : tb_lsu_subword_ctrl
// Description : Directed self-checking bench for lsu_subword_ctrl; a 32-bit
//               instance (short timeout) and a 64-bit instance share clock
//               and reset, each backed by a small cache responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_subword_ctrl;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- 32-bit instance ----------------
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, dmemREN, dmemWEN, dhit;
  logic [31:0] resp_rdata, dmemaddr, dmemstore, dmemload;
  logic [1:0]  resp_fault;

  lsu_subword_ctrl #(.WORD_W(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u_dut_a (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit)
  );

  logic [31:0] memA [256];
  logic        a_nohit = 1'b0;
  int          a_delay = 0;
  int          a_wait = 0, a_ren_cyc = 0, a_wen_cyc = 0, a_wr_cnt = 0, a_resp_cnt = 0;
  logic [31:0] a_last_wr = '0, a_last_addr = '0;
  logic        a_pl_en = 1'b0;
  logic [7:0]  a_pl_idx = '0;
  logic [31:0] a_pl_data = '0;

  assign dmemload = memA[dmemaddr[9:2]];
  assign dhit     = (dmemREN || dmemWEN) && !a_nohit && (a_wait >= a_delay);

  // Cache responder for the 32-bit instance.
  always @(posedge CLK) begin
    if ((dmemREN || dmemWEN) && !dhit) a_wait <= a_wait + 1;
    else                               a_wait <= 0;
    if (a_pl_en) memA[a_pl_idx] <= a_pl_data;
    else if (dmemWEN && dhit) begin
      memA[dmemaddr[9:2]] <= dmemstore;
      a_wr_cnt    <= a_wr_cnt + 1;
      a_last_wr   <= dmemstore;
      a_last_addr <= dmemaddr;
    end
    if (dmemREN)    a_ren_cyc  <= a_ren_cyc + 1;
    if (dmemWEN)    a_wen_cyc  <= a_wen_cyc + 1;
    if (resp_valid) a_resp_cnt <= a_resp_cnt + 1;
  end

  // ---------------- 64-bit instance ----------------
  logic        req_valid_b = 1'b0, req_we_b = 1'b0, req_unsigned_b = 1'b0;
  logic [1:0]  req_size_b = 2'd0;
  logic [31:0] req_addr_b = '0;
  logic [63:0] req_wdata_b = '0;
  logic        req_ready_b, resp_valid_b, dmemREN_b, dmemWEN_b, dhit_b;
  logic [63:0] resp_rdata_b, dmemstore_b, dmemload_b;
  logic [31:0] dmemaddr_b;
  logic [1:0]  resp_fault_b;

  lsu_subword_ctrl #(.WORD_W(64), .ADDR_W(32), .TIMEOUT_CYC(255)) u_dut_b (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_size(req_size_b), .req_unsigned(req_unsigned_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
    .resp_fault(resp_fault_b), .dmemREN(dmemREN_b), .dmemWEN(dmemWEN_b),
    .dmemaddr(dmemaddr_b), .dmemstore(dmemstore_b), .dmemload(dmemload_b), .dhit(dhit_b)
  );

  logic [63:0] memB [128];
  int          b_wait = 0, b_wr_cnt = 0;
  logic [63:0] b_last_wr = '0;
  logic [31:0] b_last_addr = '0;
  logic        b_pl_en = 1'b0;
  logic [6:0]  b_pl_idx = '0;
  logic [63:0] b_pl_data = '0;

  assign dmemload_b = memB[dmemaddr_b[9:3]];
  assign dhit_b     = (dmemREN_b || dmemWEN_b) && (b_wait >= 3);

  // Cache responder for the 64-bit instance: three stall cycles per access.
  always @(posedge CLK) begin
    if ((dmemREN_b || dmemWEN_b) && !dhit_b) b_wait <= b_wait + 1;
    else                                     b_wait <= 0;
    if (b_pl_en) memB[b_pl_idx] <= b_pl_data;
    else if (dmemWEN_b && dhit_b) begin
      memB[dmemaddr_b[9:3]] <= dmemstore_b;
      b_wr_cnt    <= b_wr_cnt + 1;
      b_last_wr   <= dmemstore_b;
      b_last_addr <= dmemaddr_b;
    end
  end

  // ---------------- helpers ----------------
  task automatic preload_a(input logic [7:0] idx, input logic [31:0] data);
    a_pl_en = 1'b1; a_pl_idx = idx; a_pl_data = data;
    @(negedge CLK);
    a_pl_en = 1'b0;
  endtask

  task automatic do_req_a(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic [1:0] flt);
    lat = -1; rd = 'x; flt = 'x;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      req_valid = 1'b0;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; flt = resp_fault;
        break;
      end
    end
    @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({req_ready, resp_valid, dmemREN, dmemWEN} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, resp_valid, dmemREN, dmemWEN});
    end
    n_checks++;
    if ({dmemaddr, dmemstore, resp_rdata, resp_fault} !== 98'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr %h store %h rdata %h fault %b expected all 0",
               dmemaddr, dmemstore, resp_rdata, resp_fault);
    end
    nRST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({req_ready, req_ready_b} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 11", {req_ready, req_ready_b});
    end
  endtask

  task automatic test_load_ext();
    int lat; logic [31:0] rd; logic [1:0] flt; int ren0;
    logic [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1};
    logic        uns [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ad  [5] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h102};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                             32'h80FF_7F01, 32'h0000_80FF};
    preload_a(8'h40, 32'h80FF_7F01);
    for (int k = 0; k < 5; k++) begin
      ren0 = a_ren_cyc;
      do_req_a(1'b0, sz[k], uns[k], ad[k], 32'h0, lat, rd, flt);
      n_checks++;
      if (rd !== exp[k]) begin
        n_fail++; $display("FAIL load_rdata[%0d]: got %h expected %h", k, rd, exp[k]);
      end
      n_checks++;
      if (flt !== 2'b00 || lat !== 2) begin
        n_fail++; $display("FAIL load_fault_lat[%0d]: got fault %b lat %0d expected 00/2", k, flt, lat);
      end
      n_checks++;
      if (a_ren_cyc - ren0 !== 1) begin
        n_fail++; $display("FAIL load_ren_cycles[%0d]: got %0d expected 1", k, a_ren_cyc - ren0);
      end
    end
  endtask

  task automatic test_sb_rmw();
    int lat; logic [31:0] rd; logic [1:0] flt; int ren0, wr0;
    preload_a(8'h80, 32'h1122_3344);
    ren0 = a_ren_cyc; wr0 = a_wr_cnt;
    do_req_a(1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFF_FFAA, lat, rd, flt);
    n_checks++;
    if (lat !== 3 || flt !== 2'b00 || rd !== 32'h0) begin
      n_fail++; $display("FAIL sb_resp: got lat %0d fault %b rdata %h expected 3/00/0", lat, flt, rd);
    end
    n_checks++;
    if (a_wr_cnt - wr0 !== 1 || a_ren_cyc - ren0 !== 1) begin
      n_fail++; $display("FAIL sb_access_count: got wr %0d ren %0d expected 1/1",
                         a_wr_cnt - wr0, a_ren_cyc - ren0);
    end
    n_checks++;
    if (a_last_wr !== 32'h1122_AA44 || a_last_addr !== 32'h200) begin
      n_fail++; $display("FAIL sb_store: got %h @%h expected 1122aa44 @00000200", a_last_wr, a_last_addr);
    end
    // Half store into the upper lanes of the same word.
    do_req_a(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, lat, rd, flt);
    n_checks++;
    if (a_last_wr !== 32'hBEEF_AA44) begin
      n_fail++; $display("FAIL sh_store: got %h expected beefaa44", a_last_wr);
    end
    do_req_a(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, lat, rd, flt);
    n_checks++;
    if (rd !== 32'hBEEF_AA44) begin
      n_fail++; $display("FAIL rmw_readback: got %h expected beefaa44", rd);
    end
  endtask

  task automatic test_faults();
    int lat; logic [31:0] rd; logic [1:0] flt; int ren0, wen0;
    ren0 = a_ren_cyc; wen0 = a_wen_cyc;
    do_req_a(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, lat, rd, flt);
    n_checks++;
    if (flt !== 2'b01 || lat !== 1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL misalign: got fault %b lat %0d rdata %h expected 01/1/0", flt, lat, rd);
    end
    do_req_a(1'b1, 2'd2, 1'b0, 32'h302, 32'h1234_5678, lat, rd, flt);
    n_checks++;
    if (flt !== 2'b01 || lat !== 1) begin
      n_fail++; $display("FAIL misalign_sw: got fault %b lat %0d expected 01/1", flt, lat);
    end
    do_req_a(1'b0, 2'd3, 1'b0, 32'h101, 32'h0, lat, rd, flt);
    n_checks++;
    if (flt !== 2'b11 || lat !== 1) begin
      n_fail++; $display("FAIL illegal_size: got fault %b lat %0d expected 11/1", flt, lat);
    end
    n_checks++;
    if (a_ren_cyc - ren0 !== 0 || a_wen_cyc - wen0 !== 0) begin
      n_fail++; $display("FAIL fault_no_access: got ren %0d wen %0d expected 0/0",
                         a_ren_cyc - ren0, a_wen_cyc - wen0);
    end
  endtask

  task automatic test_timeout();
    int lat; logic [31:0] rd; logic [1:0] flt; int ren0, wen0, wr0;
    a_nohit = 1'b1;
    wen0 = a_wen_cyc; wr0 = a_wr_cnt;
    do_req_a(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEAD_BEEF, lat, rd, flt);
    n_checks++;
    if (flt !== 2'b10 || lat !== 5) begin
      n_fail++; $display("FAIL sw_timeout: got fault %b lat %0d expected 10/5", flt, lat);
    end
    n_checks++;
    if (a_wen_cyc - wen0 !== 4 || a_wr_cnt - wr0 !== 0) begin
      n_fail++; $display("FAIL sw_timeout_wen: got wen %0d writes %0d expected 4/0",
                         a_wen_cyc - wen0, a_wr_cnt - wr0);
    end
    ren0 = a_ren_cyc; wen0 = a_wen_cyc;
    do_req_a(1'b1, 2'd0, 1'b0, 32'h300, 32'h0000_0011, lat, rd, flt);
    n_checks++;
    if (flt !== 2'b10 || a_ren_cyc - ren0 !== 4 || a_wen_cyc - wen0 !== 0) begin
      n_fail++; $display("FAIL rmw_timeout: got fault %b ren %0d wen %0d expected 10/4/0",
                         flt, a_ren_cyc - ren0, a_wen_cyc - wen0);
    end
    a_nohit = 1'b0; a_delay = 3;
    wen0 = a_wen_cyc; wr0 = a_wr_cnt;
    do_req_a(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEAD_BEEF, lat, rd, flt);
    n_checks++;
    if (flt !== 2'b00 || lat !== 5 || a_wen_cyc - wen0 !== 4 || a_wr_cnt - wr0 !== 1) begin
      n_fail++; $display("FAIL last_cycle_hit: got fault %b lat %0d wen %0d writes %0d expected 00/5/4/1",
                         flt, lat, a_wen_cyc - wen0, a_wr_cnt - wr0);
    end
    a_delay = 0;
  endtask

  task automatic test_reset_mid_rmw();
    int wen0, resp0;
    a_nohit = 1'b1;
    wen0 = a_wen_cyc; resp0 = a_resp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h204; req_wdata = 32'h55;
    @(negedge CLK);
    req_valid = 1'b0;
    n_checks++;
    if (dmemREN !== 1'b1) begin
      n_fail++; $display("FAIL rmw_started: got REN %b expected 1", dmemREN);
    end
    nRST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({req_ready, resp_valid, dmemREN, dmemWEN} !== 4'b0000 ||
        {dmemaddr, dmemstore, resp_rdata, resp_fault} !== 98'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got ctrl %b addr %h store %h rdata %h fault %b expected all 0",
                         {req_ready, resp_valid, dmemREN, dmemWEN}, dmemaddr, dmemstore, resp_rdata, resp_fault);
    end
    nRST = 1'b1; a_nohit = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b expected 1", req_ready);
    end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (a_wen_cyc - wen0 !== 0 || a_resp_cnt - resp0 !== 0) begin
      n_fail++; $display("FAIL abandoned_rmw: got wen %0d resp %0d expected 0/0",
                         a_wen_cyc - wen0, a_resp_cnt - resp0);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2, acc2; logic early; logic seen1;
    logic [1:0] f1, f2; logic [63:0] rd1, rd2;
    c1 = -1; c2 = -1; acc2 = -1; early = 1'b0; seen1 = 1'b0;
    f1 = 'x; f2 = 'x; rd1 = 'x; rd2 = 'x;
    b_pl_en = 1'b1; b_pl_idx = 7'd1; b_pl_data = 64'h0123_4567_89AB_CDEF;
    @(negedge CLK);
    b_pl_en = 1'b0;
    req_valid_b = 1'b1; req_we_b = 1'b1; req_size_b = 2'd2; req_unsigned_b = 1'b0;
    req_addr_b = 32'h0C; req_wdata_b = 64'h0000_0000_CAFE_F00D;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        req_we_b = 1'b0; req_size_b = 2'd3; req_addr_b = 32'h08; req_wdata_b = '0;
      end
      if (acc2 >= 0 && c == acc2 + 1) req_valid_b = 1'b0;
      if (req_ready_b && !seen1) early = 1'b1;
      if (req_ready_b && seen1 && acc2 < 0) acc2 = c;
      if (resp_valid_b) begin
        if (!seen1) begin
          seen1 = 1'b1; c1 = c; f1 = resp_fault_b; rd1 = resp_rdata_b;
        end else begin
          c2 = c; f2 = resp_fault_b; rd2 = resp_rdata_b;
          break;
        end
      end
    end
    req_valid_b = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (early !== 1'b0 || c1 !== 9 || f1 !== 2'b00 || rd1 !== 64'h0) begin
      n_fail++; $display("FAIL b2b_first: got early %b lat %0d fault %b rdata %h expected 0/9/00/0",
                         early, c1, f1, rd1);
    end
    n_checks++;
    if (b_last_wr !== 64'hCAFE_F00D_89AB_CDEF || b_last_addr !== 32'h08 || b_wr_cnt !== 1) begin
      n_fail++; $display("FAIL b2b_store: got %h @%h writes %0d expected cafef00d89abcdef @00000008 1",
                         b_last_wr, b_last_addr, b_wr_cnt);
    end
    n_checks++;
    if (acc2 !== c1 + 1 || c2 - acc2 !== 5 || f2 !== 2'b00) begin
      n_fail++; $display("FAIL b2b_second_timing: got ready@%0d resp@%0d fault %b expected ready@%0d lat 5 fault 00",
                         acc2, c2, f2, c1 + 1);
    end
    n_checks++;
    if (rd2 !== 64'hCAFE_F00D_89AB_CDEF) begin
      n_fail++; $display("FAIL b2b_load: got %h expected cafef00d89abcdef", rd2);
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_sb_rmw();
    test_faults();
    test_timeout();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
